muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. Sits directly downstream of `regfiles`: its two operands are the register file read ports (`data_a` = rs, `data_b` = rt) captured in the execute stage. It runs MULT/MULTU/DIV/DIVU over multiple cycles and handles MTHI/MTLO in one cycle. It exposes `busy` so the pipeline can stall MFHI/MFLO and any new mul/div until the result is committed.

---
 rtl/muldiv_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are reserved.
module muldiv_unit (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;
  logic [5:0]  cnt;
  logic [63:0] acc, step, prod;
  logic [31:0] b_mag, res_hi, res_lo;
  logic        neg_q, sgn, a_neg, b_neg, accept_md, div_op, go;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  assign sgn     = ~op[0];
  assign a_neg   = sgn & src_a[31];
  assign b_neg   = sgn & src_b[31];
  assign a_abs   = a_neg ? -src_a : src_a;
  assign b_abs   = b_neg ? -src_b : src_b;
  assign busy    = state != IDLE;
  assign go      = state == IDLE && start && accept_md;
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
  assign mul_nx  = {mul_sum, acc[31:1]};
  assign prod    = neg_q ? -acc : acc;
`ifdef MULDIV_DIV_EN
  logic        is_div, neg_r;
  logic [33:0] div_diff;
  logic [63:0] div_nx;
  assign accept_md = ~op[2];
  assign div_op    = op[1];
  // Restoring step: the shifted partial remainder needs 33 bits before the compare.
  assign div_diff  = {1'b0, acc[63:31]} - {2'b00, b_mag};
  assign div_nx    = div_diff[33] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
  assign step      = is_div ? div_nx : mul_nx;
  // With a zero divisor the remainder naturally ends as the signed dividend.
  assign res_hi    = is_div ? (neg_r ? -acc[63:32] : acc[63:32]) : prod[63:32];
  assign res_lo    = is_div ? (b_mag == 32'd0 ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0])) : prod[31:0];
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      is_div <= 1'b0;
      neg_r  <= 1'b0;
    end else if (go) begin
      is_div <= op[1];
      neg_r  <= a_neg;
    end
`else
  assign accept_md = op[2:1] == 2'b00;
  assign div_op    = 1'b0;
  assign step      = mul_nx;
  assign res_hi    = prod[63:32];
  assign res_lo    = prod[31:0];
`endif
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = go ? RUN : IDLE;
    else if (state == RUN) state_nx = cnt == 6'd31 ? FIX : RUN;
  end
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge aclr_n)
    if (!aclr_n) begin
      cnt   <= '0;
      acc   <= '0;
      b_mag <= '0;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= state == FIX;
      if (state == IDLE && start && op == 3'b100) hi <= src_a;
      if (state == IDLE && start && op == 3'b101) lo <= src_a;
      if (go) begin
        acc   <= {32'd0, div_op ? a_abs : b_abs};
        b_mag <= div_op ? b_abs : a_abs;
        neg_q <= a_neg ^ b_neg;
        cnt   <= '0;
      end
      if (state == RUN) begin
        acc <= step;
        cnt <= cnt + 6'd1;
      end
      if (state == FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
endmodule
